// File: rtl/op_sweeper.sv
// op_sweeper: steps operand pairs through a start/busy engine,
// summing results and flagging handshake timeouts.
module op_sweeper #(
  parameter int W        = 8,
  parameter int RES_W    = 16,
  parameter int ACC_W    = 24,
  parameter int A0       = 0,
  parameter int B0       = 0,
  parameter int STEP     = 15,
  parameter int LIMIT    = 241,
  parameter int BUSY_TMO = 4,
  parameter int DONE_TMO = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             busy,
  input  logic [RES_W-1:0] res,
  output logic [W-1:0]     a,
  output logic [W-1:0]     b,
  output logic             start,
  output logic             done,
  output logic             err,
  output logic [7:0]       op_cnt,
  output logic [ACC_W-1:0] acc,
  output logic [RES_W-1:0] last_res
);

  localparam int TMAX = (BUSY_TMO > DONE_TMO) ? BUSY_TMO : DONE_TMO;
  localparam int CW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WBUSY, S_WDONE, S_CAPT, S_DONE, S_ERR
  } st_t;

  st_t              state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic             done_q, done_d, err_q, err_d;
  logic [7:0]       op_cnt_q, op_cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [RES_W-1:0] last_q, last_d;

  logic rest, busy_to, done_to, last_op;

  assign rest    = state_q inside {S_IDLE, S_DONE, S_ERR};
  assign busy_to = cnt_q == CW'(BUSY_TMO - 1);
  assign done_to = cnt_q == CW'(DONE_TMO - 1);
  assign last_op = a_q >= W'(LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= W'(A0);
      b_q      <= W'(B0);
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      op_cnt_q <= '0;
      acc_q    <= '0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      done_q   <= done_d;
      err_q    <= err_d;
      op_cnt_q <= op_cnt_d;
      acc_q    <= acc_d;
      last_q   <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR:
        if (run) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WBUSY;
      S_WBUSY:
        if (busy)         state_d = S_WDONE;
        else if (busy_to) state_d = S_ERR;
      S_WDONE:
        if (!busy)        state_d = S_CAPT;
        else if (done_to) state_d = S_ERR;
      S_CAPT:
        state_d = last_op ? S_DONE : S_ISSUE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    start    = state_q == S_ISSUE;
    cnt_d    = '0;
    a_d      = a_q;
    b_d      = b_q;
    done_d   = done_q;
    err_d    = err_q;
    op_cnt_d = op_cnt_q;
    acc_d    = acc_q;
    last_d   = last_q;
    // counter restarts on every state entry
    if (state_q inside {S_WBUSY, S_WDONE} && state_d == state_q)
      cnt_d = cnt_q + CW'(1);
    if (rest && run) begin
      a_d      = W'(A0);
      b_d      = W'(B0);
      op_cnt_d = '0;
      acc_d    = '0;
      done_d   = 1'b0;
      err_d    = 1'b0;
    end
    if (state_q == S_WDONE && !busy)
      last_d = res;
    if (state_d == S_ERR && !rest)
      err_d = 1'b1;
    if (state_q == S_CAPT) begin
      acc_d = acc_q + ACC_W'(last_q);
      if (op_cnt_q != 8'hFF)
        op_cnt_d = op_cnt_q + 8'd1;
      if (last_op) begin
        done_d = 1'b1;
      end else begin
        a_d = a_q + W'(STEP);
        b_d = b_q + W'(STEP);
      end
    end
  end

  assign a        = a_q;
  assign b        = b_q;
  assign done     = done_q;
  assign err      = err_q;
  assign op_cnt   = op_cnt_q;
  assign acc      = acc_q;
  assign last_res = last_q;

endmodule

// File: tb/tb_op_sweeper.sv
// tb_op_sweeper: mock start/busy engine, operand scoreboard,
// table of engine timings plus reset and run-held sequences.
module tb_op_sweeper;

  localparam int W        = 8;
  localparam int RES_W    = 16;
  localparam int ACC_W    = 24;
  localparam int A0       = 0;
  localparam int B0       = 0;
  localparam int STEP     = 15;
  localparam int LIMIT    = 241;
  localparam int BUSY_TMO = 4;
  localparam int DONE_TMO = 1024;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             run = 1'b0;
  logic             busy = 1'b0;
  logic [RES_W-1:0] res = 16'hBEEF;
  logic [W-1:0]     a, b;
  logic             start, done, err;
  logic [7:0]       op_cnt;
  logic [ACC_W-1:0] acc;
  logic [RES_W-1:0] last_res;

  op_sweeper #(
    .W(W), .RES_W(RES_W), .ACC_W(ACC_W), .A0(A0), .B0(B0),
    .STEP(STEP), .LIMIT(LIMIT), .BUSY_TMO(BUSY_TMO),
    .DONE_TMO(DONE_TMO)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .busy(busy), .res(res),
    .a(a), .b(b), .start(start), .done(done), .err(err),
    .op_cnt(op_cnt), .acc(acc), .last_res(last_res)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // mock engine: mode 0 timed, 1 never busy, 2 busy forever
  int        eng_mode = 0, eng_d = 0, eng_l = 1, eng_n = 0;
  bit        eng_early = 1'b0, eng_act = 1'b0;
  logic [15:0] eng_prod = '0;

  always @(negedge clk) begin
    if (!rst) begin
      busy = 1'b0;
      res = 16'hBEEF;
      eng_act = 1'b0;
    end else begin
      res = 16'hBEEF;
      if (start) begin
        eng_act = 1'b1;
        eng_n = 0;
        eng_prod = {8'b0, a} * {8'b0, b};
        busy = eng_early && eng_mode != 1;
      end else if (eng_act) begin
        eng_n++;
        if (eng_mode == 1) busy = 1'b0;
        else if (eng_mode == 2) busy = 1'b1;
        else if (eng_n <= eng_d) busy = 1'b0;
        else if (eng_n <= eng_d + eng_l) busy = 1'b1;
        else begin
          busy = 1'b0;
          res = eng_prod;
          eng_act = 1'b0;
        end
      end
    end
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
  } pair_t;
  pair_t q[$];

  int n_starts = 0, prev_start = -1, first_start = -1, gap1 = -1;

  always @(negedge clk) begin
    if (start) begin
      n_starts++;
      if (first_start < 0) first_start = cyc;
      if (prev_start >= 0 && gap1 < 0) gap1 = cyc - prev_start;
      prev_start = cyc;
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL start_unexpected: got start=1 a=%0d want no start",
                 a);
      end else begin
        pair_t p;
        p = q.pop_front();
        chk("start_a", a, p.a);
        chk("start_b", b, p.b);
      end
    end
  end

  typedef struct {
    int mode; int d; int l; bit early;
    int ops; bit fdone; bit ferr;
    int facc; int flast; int fa;
    int span; int elat;
  } vec_t;
  vec_t tbl[9];

  task automatic push_sweep(input int n);
    for (int k = 0; k < n; k++) begin
      pair_t p;
      p.a = 8'(A0 + k * STEP);
      p.b = 8'(B0 + k * STEP);
      q.push_back(p);
    end
  endtask

  task automatic wait_end(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done || err) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_vec(input int i, input vec_t v);
    bit ok;
    @(negedge clk);
    eng_mode = v.mode;
    eng_d = v.d;
    eng_l = v.l;
    eng_early = v.early;
    push_sweep(v.ops == 0 ? 1 : v.ops);
    prev_start = -1;
    first_start = -1;
    gap1 = -1;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    chk($sformatf("v%0d_done_clr", i), done, 0);
    chk($sformatf("v%0d_err_clr", i), err, 0);
    chk($sformatf("v%0d_acc_clr", i), acc, 0);
    wait_end(30000, ok);
    chk($sformatf("v%0d_finished", i), ok, 1);
    chk($sformatf("v%0d_done", i), done, v.fdone);
    chk($sformatf("v%0d_err", i), err, v.ferr);
    chk($sformatf("v%0d_op_cnt", i), op_cnt, v.ops);
    chk($sformatf("v%0d_acc", i), acc, v.facc);
    chk($sformatf("v%0d_last_res", i), last_res, v.flast);
    chk($sformatf("v%0d_a", i), a, v.fa);
    chk($sformatf("v%0d_b", i), b, v.fa);
    chk($sformatf("v%0d_queue_left", i), q.size(), 0);
    if (v.span >= 0)
      chk($sformatf("v%0d_span", i), gap1 + 1, v.span);
    if (v.elat >= 0)
      chk($sformatf("v%0d_err_lat", i), cyc - first_start, v.elat);
    q.delete();
  endtask

  initial begin
    int snap, dcyc;
    bit ok;
    if (LIMIT + STEP > 2 ** W) begin
      $display("FAIL param_check: LIMIT+STEP=%0d exceeds %0d",
               LIMIT + STEP, 2 ** W);
      $fatal(1);
    end
    //            mode d  l    erl ops dn er acc     last   fa  span  elat
    tbl[0] = '{0, 0, 3,    1'b0, 18, 1'b1, 1'b0, 401625, 65025, 255, 7, -1};
    tbl[1] = '{0, 0, 1,    1'b0, 18, 1'b1, 1'b0, 401625, 65025, 255, 5, -1};
    tbl[2] = '{0, 0, 1,    1'b1, 18, 1'b1, 1'b0, 401625, 65025, 255, 5, -1};
    tbl[3] = '{0, 3, 1,    1'b0, 18, 1'b1, 1'b0, 401625, 65025, 255, 8, -1};
    tbl[4] = '{0, 4, 1,    1'b0, 0,  1'b0, 1'b1, 0,      65025, 0,  -1, 5};
    tbl[5] = '{1, 0, 1,    1'b0, 0,  1'b0, 1'b1, 0,      65025, 0,  -1, 5};
    tbl[6] = '{2, 0, 1,    1'b0, 0,  1'b0, 1'b1, 0,      65025, 0,  -1, 1026};
    tbl[7] = '{0, 0, 1024, 1'b0, 18, 1'b1, 1'b0, 401625, 65025, 255, 1028, -1};
    tbl[8] = '{0, 0, 1025, 1'b0, 0,  1'b0, 1'b1, 0,      65025, 0,  -1, 1026};

    repeat (3) @(negedge clk);
    chk("rst_a", a, A0);
    chk("rst_b", b, B0);
    chk("rst_start", start, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_op_cnt", op_cnt, 0);
    chk("rst_acc", acc, 0);
    chk("rst_last_res", last_res, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_no_start", n_starts, 0);

    for (int i = 0; i < 9; i++) run_vec(i, tbl[i]);

    // async reset mid-sweep while waiting on busy at a=90
    @(negedge clk);
    eng_mode = 0; eng_d = 0; eng_l = 3; eng_early = 1'b0;
    push_sweep(18);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (start && a == 8'd90) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("rst_reach_a90", ok, 1);
    repeat (2) @(negedge clk);
    chk("mid_busy_high", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_a", a, A0);
    chk("arst_b", b, B0);
    chk("arst_start", start, 0);
    chk("arst_op_cnt", op_cnt, 0);
    chk("arst_acc", acc, 0);
    chk("arst_last_res", last_res, 0);
    chk("arst_done", done, 0);
    chk("arst_err", err, 0);
    q.delete();
    snap = n_starts;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("arst_no_start", n_starts - snap, 0);

    // run held high: back-to-back sweeps
    eng_mode = 0; eng_d = 0; eng_l = 1; eng_early = 1'b0;
    push_sweep(18);
    push_sweep(18);
    run = 1'b1;
    wait_end(2000, ok);
    chk("hold_done1", done, 1);
    dcyc = cyc;
    ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (start) begin
        ok = 1'b1;
        break;
      end
    end
    chk("hold_restart_seen", ok, 1);
    chk("hold_restart_gap", cyc - dcyc, 1);
    chk("hold_done_clr", done, 0);
    wait_end(2000, ok);
    run = 1'b0;
    chk("hold_done2", done, 1);
    @(negedge clk);
    chk("hold_done_stays", done, 1);
    chk("hold_op_cnt", op_cnt, 18);
    chk("hold_acc", acc, 401625);
    chk("hold_queue_left", q.size(), 0);
    repeat (5) @(negedge clk);
    chk("hold_no_third", start, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
